// File: rtl/wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// wb_arbiter_rr
//
// Round-robin Wishbone arbiter that shares one slave port between NUM_MASTERS
// masters. Ownership is granted for a whole bus cycle (cyc high), including
// bursts and strobe gaps. The master that owned the bus last gets the lowest
// priority in the next arbitration.
//
// Optional feature (macro WB_ARBITER_RR_WATCHDOG_EN): a bus watchdog that
// terminates a strobe left unanswered for TIMEOUT cycles. The owner gets a
// one-cycle err and the slave sees cyc dropped until the owner releases the bus.
//
// Parameters:
//   NUM_MASTERS  number of masters (2..8)
//   AW / DW      address / data width, sel width is DW/8
//   TIMEOUT      unanswered strobe cycles before forced termination (1..65535)
//
// Ports:
//   wb_clk_i, wb_rst_n_i      clock, asynchronous active-low reset
//   wbm_*_i                   packed master requests, master 0 in the LSBs
//   wbm_dat_o                 read data broadcast to all masters
//   wbm_ack_o/err_o/rty_o     per-master responses, only the owner sees them
//   wbs_*_o / wbs_*_i         shared slave request / response
//   grant_o                   one-hot current owner, 0 when idle
//   timeout_o                 one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DW / 8;
  localparam logic [IW-1:0]          LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
`ifdef WB_ARBITER_RR_WATCHDOG_EN
    ,
    ST_TERM = 2'd2
`endif
  } state_t;

  state_t                 state_r, state_n;
  logic [IW-1:0]          owner_r, owner_n;
  logic [IW-1:0]          last_r, last_n;
  logic [NUM_MASTERS-1:0] grant_r, grant_n;

  logic [IW-1:0]          pick_s;
  logic [IW-1:0]          cand_s;
  logic                   any_req_s;
  logic                   busy_s;
  logic                   resp_s;
  logic                   expire_s;

  logic [AW-1:0]          own_adr_s;
  logic [DW-1:0]          own_dat_s;
  logic [SW-1:0]          own_sel_s;
  logic                   own_we_s;
  logic                   own_cyc_s;
  logic                   own_stb_s;
  logic [2:0]             own_cti_s;
  logic [1:0]             own_bte_s;
  logic                   stb_req_s;

  assign any_req_s = |wbm_cyc_i;
  assign busy_s    = (state_r == ST_BUSY);
  assign resp_s    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign stb_req_s = own_cyc_s & own_stb_s;
  assign grant_o   = grant_r;
  assign wbm_dat_o = wbs_dat_i;

  // Round-robin pick: scan downward from the farthest candidate so the
  // requester closest after last_r is written last and wins.
  always_comb begin
    pick_s = last_r;
    cand_s = {IW{1'b0}};
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand_s = IW'((int'(last_r) + k) % NUM_MASTERS);
      pick_s = wbm_cyc_i[cand_s] ? cand_s : pick_s;
    end
  end

  // Owner request mux, AND-OR selected by the one-hot grant register.
  always_comb begin
    own_adr_s = {AW{1'b0}};
    own_dat_s = {DW{1'b0}};
    own_sel_s = {SW{1'b0}};
    own_we_s  = 1'b0;
    own_cyc_s = |(wbm_cyc_i & grant_r);
    own_stb_s = |(wbm_stb_i & grant_r);
    own_cti_s = 3'b000;
    own_bte_s = 2'b00;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      own_adr_s = own_adr_s | ({AW{grant_r[i]}} & wbm_adr_i[i*AW +: AW]);
      own_dat_s = own_dat_s | ({DW{grant_r[i]}} & wbm_dat_i[i*DW +: DW]);
      own_sel_s = own_sel_s | ({SW{grant_r[i]}} & wbm_sel_i[i*SW +: SW]);
      own_we_s  = own_we_s  | (grant_r[i] & wbm_we_i[i]);
      own_cti_s = own_cti_s | ({3{grant_r[i]}} & wbm_cti_i[i*3 +: 3]);
      own_bte_s = own_bte_s | ({2{grant_r[i]}} & wbm_bte_i[i*2 +: 2]);
    end
  end

`ifdef WB_ARBITER_RR_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt_r;

  // Watchdog counter: counts consecutive unanswered strobe cycles of the owner.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt_r <= 16'd0;
    end else if (!busy_s || !stb_req_s || resp_s) begin
      wd_cnt_r <= 16'd0;
    end else begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end
  end

  // A slave response in the expiry cycle takes precedence over the timeout.
  assign expire_s  = busy_s & stb_req_s & ~resp_s & (wd_cnt_r == WD_LIMIT);
  assign timeout_o = expire_s;
`else
  assign expire_s  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Arbitration state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r <= ST_IDLE;
      owner_r <= {IW{1'b0}};
      last_r  <= LAST_RST;
      grant_r <= {NUM_MASTERS{1'b0}};
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      last_r  <= last_n;
      grant_r <= grant_n;
    end
  end

  // Next-state logic: grant in IDLE, hold for the whole cycle, release on cyc low.
  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    last_n  = last_r;
    grant_n = grant_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_n = ST_BUSY;
          owner_n = pick_s;
          grant_n = ONE_HOT0 << pick_s;
        end else begin
          grant_n = {NUM_MASTERS{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!own_cyc_s) begin
          state_n = ST_IDLE;
          last_n  = owner_r;
          grant_n = {NUM_MASTERS{1'b0}};
        end else if (expire_s) begin
`ifdef WB_ARBITER_RR_WATCHDOG_EN
          state_n = ST_TERM;
`else
          state_n = ST_BUSY;
`endif
        end else begin
          state_n = ST_BUSY;
        end
      end
`ifdef WB_ARBITER_RR_WATCHDOG_EN
      ST_TERM: begin
        if (!own_cyc_s) begin
          state_n = ST_IDLE;
          last_n  = owner_r;
          grant_n = {NUM_MASTERS{1'b0}};
        end else begin
          state_n = ST_TERM;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        grant_n = {NUM_MASTERS{1'b0}};
      end
    endcase
  end

  // Slave request and master responses; everything is quiet outside BUSY.
  always_comb begin
    wbs_adr_o = {AW{1'b0}};
    wbs_dat_o = {DW{1'b0}};
    wbs_sel_o = {SW{1'b0}};
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = 3'b000;
    wbs_bte_o = 2'b00;
    wbm_ack_o = {NUM_MASTERS{1'b0}};
    wbm_err_o = {NUM_MASTERS{1'b0}};
    wbm_rty_o = {NUM_MASTERS{1'b0}};
    if (busy_s) begin
      wbs_adr_o = own_adr_s;
      wbs_dat_o = own_dat_s;
      wbs_sel_o = own_sel_s;
      wbs_we_o  = own_we_s;
      wbs_cyc_o = own_cyc_s;
      wbs_stb_o = stb_req_s;
      wbs_cti_o = own_cti_s;
      wbs_bte_o = own_bte_s;
      wbm_ack_o = grant_r & {NUM_MASTERS{wbs_ack_i}};
      wbm_err_o = grant_r & {NUM_MASTERS{wbs_err_i | expire_s}};
      wbm_rty_o = grant_r & {NUM_MASTERS{wbs_rty_i}};
    end else begin
      wbm_ack_o = {NUM_MASTERS{1'b0}};
    end
  end

endmodule
